// File: rtl/clk_seq_pkg.sv
// Shared types and default constants for the clock/reset sequencer.
// Optional feature macro used by clk_reset_seq: CLK_SEQ_PAUSE_EN (adds a pause input).
package clk_seq_pkg;

  // Sequencer states: wait for lock, qualify lock, hold reset, run.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned LOCK_STABLE_DEF = 1024;
  localparam int unsigned RST_HOLD_DEF    = 256;
  localparam int unsigned CE_DIV_DEF      = 8;

  // Lock-qualify / reset-hold counter width.
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit double-flop synchronizer, asynchronously cleared to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first one a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_reset_seq.sv
// Clock/reset sequencer: qualifies PLL lock, holds the core in reset for a
// fixed time, then releases it and generates pixel/half-rate clock enables.
// Optional build macro CLK_SEQ_PAUSE_EN adds a pause input that freezes the
// clock-enable divider while in RUN without touching the FSM or core_rst.
module clk_reset_seq
  import clk_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = LOCK_STABLE_DEF,
  parameter int unsigned RST_HOLD    = RST_HOLD_DEF,
  parameter int unsigned CE_DIV      = CE_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
`ifdef CLK_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic       core_rst,
  output logic       ce_pix,
  output logic       ce_half,
  output logic       ready,
  output seq_state_e dbg_state
);

  localparam int unsigned DIV_W = $clog2(2 * CE_DIV);
  localparam logic [DIV_W-1:0] PIX_MASK  = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CE_DIV - 1);
  localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(RST_HOLD - 1);

  logic locked_s;
  logic pause_w;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             core_rst_q, core_rst_d;
  logic             ce_pix_q, ce_pix_d;
  logic             ce_half_q, ce_half_d;
  logic             ready_q, ready_d;
  logic             run_stay;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

`ifdef CLK_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // Next-state logic: lock qualification, reset hold, and any loss of lock
  // sends the sequencer straight back to WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_END) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_END) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Divider and strobes: only advance while staying in RUN, so the divider
  // enters RUN at 0 and strobes can never appear on the exit cycle.
  always_comb begin
    run_stay  = (state_q == RUN) && (state_d == RUN);
    div_cnt_d = '0;
    ce_pix_d  = 1'b0;
    ce_half_d = 1'b0;
    if (run_stay) begin
      if (pause_w) begin
        div_cnt_d = div_cnt_q;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        ce_pix_d  = (div_cnt_q & PIX_MASK) == PIX_MASK;
        ce_half_d = (div_cnt_q == DIV_LAST);
      end
    end
    core_rst_d = (state_d != RUN);
    ready_d    = (state_d == RUN);
  end

  // All state and outputs registered; reset forces the safe (in-reset) values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      div_cnt_q  <= '0;
      core_rst_q <= 1'b1;
      ce_pix_q   <= 1'b0;
      ce_half_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cnt_q  <= div_cnt_d;
      core_rst_q <= core_rst_d;
      ce_pix_q   <= ce_pix_d;
      ce_half_q  <= ce_half_d;
      ready_q    <= ready_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign ce_pix    = ce_pix_q;
  assign ce_half   = ce_half_q;
  assign ready     = ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Bench for clk_reset_seq with LOCK_STABLE=4, RST_HOLD=3, CE_DIV=8.
// Reference model: state follows from the length of the current run of
// synchronized-lock cycles; strobes follow from the count of active RUN cycles.
module tb_clk_reset_seq;

  localparam int LS = 4;
  localparam int RH = 3;
  localparam int CD = 8;
  localparam int TH = 1 + LS + RH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pause = 1'b0;
  logic       core_rst, ce_pix, ce_half, ready;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  // model state
  int m_s1 = 0, m_ls = 0, m_streak = 0, m_act = 0;
  bit m_run = 0, m_pix = 0, m_half = 0;

  clk_reset_seq #(.LOCK_STABLE(LS), .RST_HOLD(RH), .CE_DIV(CD)) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
`ifdef CLK_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .core_rst   (core_rst),
    .ce_pix     (ce_pix),
    .ce_half    (ce_half),
    .ready      (ready),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // One active edge of the reference model.
  task automatic model_edge();
    bit prev_run;
    if (rst) begin
      m_s1 = 0; m_ls = 0; m_streak = 0; m_act = 0;
      m_run = 0; m_pix = 0; m_half = 0;
    end else begin
      prev_run = (m_streak >= TH);
      if (m_ls != 0) m_streak = (m_streak < 100000) ? m_streak + 1 : m_streak;
      else m_streak = 0;
      m_ls = m_s1;
      m_s1 = pll_locked ? 1 : 0;
      m_run = (m_streak >= TH);
      m_pix = 0;
      m_half = 0;
      if (m_run && prev_run) begin
        if (!pause) begin
          m_act++;
          m_pix  = (m_act % CD) == 0;
          m_half = (m_act % (2 * CD)) == 0;
        end
      end else begin
        m_act = 0;
      end
    end
  endtask

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; pll_locked = 0; pause = 0;
    tick(); tick();
    tests++;
    if ({core_rst, ready, ce_pix, ce_half} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_values got=%b want=1000", {core_rst, ready, ce_pix, ce_half});
    end
    tests++;
    if (dbg_state !== 2'd0) begin
      fails++;
      $display("FAIL reset_state got=%0d want=0", dbg_state);
    end
    rst = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      tests++;
      if ({core_rst, ready, ce_pix, ce_half} !== 4'b1000) begin
        fails++;
        $display("FAIL no_lock cyc=%0d got=%b want=1000", i, {core_rst, ready, ce_pix, ce_half});
      end
    end
  endtask

  task automatic test_lock_timing();
    bit er, ep, eh;
    pll_locked = 1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      er = (i < 10);
      ep = (i >= 18) && (((i - 10) % CD) == 0);
      eh = (i >= 26) && (((i - 10) % (2 * CD)) == 0);
      tests++;
      if ({core_rst, ready, ce_pix, ce_half} !== {er, !er, ep, eh}) begin
        fails++;
        $display("FAIL lock_timing edge=%0d got=%b want=%b", i,
                 {core_rst, ready, ce_pix, ce_half}, {er, !er, ep, eh});
      end
    end
  endtask

  task automatic test_glitch_stable();
    pll_locked = 0;
    for (int i = 0; i < 6; i++) tick();
    pll_locked = 1;
    for (int i = 0; i < 4; i++) tick();
    pll_locked = 0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      pll_locked = 1;
      tests++;
      if ({core_rst, ready} !== {(j < 11), (j >= 11)} ||
          {core_rst, ready, ce_pix, ce_half} !== {!m_run, m_run, m_pix, m_half}) begin
        fails++;
        $display("FAIL glitch_stable edge=%0d got=%b want_rst=%0d", j,
                 {core_rst, ready, ce_pix, ce_half}, (j < 11));
      end
    end
  endtask

  task automatic test_run_loss();
    int n;
    n = $urandom_range(5, 30);
    for (int i = 0; i < n; i++) tick();
    pll_locked = 0;
    for (int j = 1; j <= 3; j++) tick();
    tests++;
    if ({core_rst, ready, ce_pix, ce_half} !== 4'b1000) begin
      fails++;
      $display("FAIL run_loss_3cyc got=%b want=1000", {core_rst, ready, ce_pix, ce_half});
    end
    for (int j = 0; j < 20; j++) begin
      tick();
      tests++;
      if ({core_rst, ready, ce_pix, ce_half} !== 4'b1000) begin
        fails++;
        $display("FAIL run_loss_quiet cyc=%0d got=%b want=1000", j,
                 {core_rst, ready, ce_pix, ce_half});
      end
    end
    pll_locked = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      tests++;
      if ({core_rst, ready, ce_pix} !== {(i < 10), (i >= 10), (i == 18)}) begin
        fails++;
        $display("FAIL relock_timing edge=%0d got=%b want_rst=%0d", i,
                 {core_rst, ready, ce_pix}, (i < 10));
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = $urandom_range(3, 20);
    for (int i = 0; i < n; i++) tick();
    #2 rst = 1;
    #1;
    tests++;
    if ({core_rst, ready, ce_pix, ce_half} !== 4'b1000 || dbg_state !== 2'd0) begin
      fails++;
      $display("FAIL async_reset got=%b state=%0d want=1000 state=0",
               {core_rst, ready, ce_pix, ce_half}, dbg_state);
    end
    tick();
    rst = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      tests++;
      if ({core_rst, ready} !== {(i < 10), (i >= 10)}) begin
        fails++;
        $display("FAIL reset_restart edge=%0d got=%b want_rst=%0d", i,
                 {core_rst, ready}, (i < 10));
      end
    end
  endtask

`ifdef CLK_SEQ_PAUSE_EN
  task automatic test_pause();
    int k, want, got;
    pll_locked = 1;
    for (int i = 0; i < 40 && !m_run; i++) tick();
    k = $urandom_range(1, 30);
    for (int i = 0; i < k; i++) tick();
    want = CD - (m_act % CD);
    pause = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if ({core_rst, ready, ce_pix, ce_half} !== 4'b0100) begin
        fails++;
        $display("FAIL pause_hold cyc=%0d got=%b want=0100", i,
                 {core_rst, ready, ce_pix, ce_half});
      end
    end
    pause = 0;
    got = -1;
    for (int i = 1; i <= 2 * CD && got < 0; i++) begin
      tick();
      if (ce_pix === 1'b1) got = i;
    end
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL pause_resume_phase got=%0d want=%0d", got, want);
    end
  endtask
`endif

  task automatic test_random();
    int seg;
    bit val;
    seg = 0;
    val = 1;
    for (int i = 0; i < 2000; i++) begin
      if (seg == 0) begin
        val = ($urandom_range(0, 3) != 0);
        seg = val ? $urandom_range(1, 60) : $urandom_range(1, 6);
      end
      pll_locked = val;
      seg--;
`ifdef CLK_SEQ_PAUSE_EN
      pause = ($urandom_range(0, 9) == 0);
`endif
      tick();
      tests++;
      if ({core_rst, ready, ce_pix, ce_half} !== {!m_run, m_run, m_pix, m_half}) begin
        fails++;
        $display("FAIL random cyc=%0d got=%b want=%b", i,
                 {core_rst, ready, ce_pix, ce_half}, {!m_run, m_run, m_pix, m_half});
      end
    end
    pause = 0;
  endtask

  initial begin
    test_reset();
    test_lock_timing();
    test_glitch_stable();
    test_run_loss();
    test_async_reset();
`ifdef CLK_SEQ_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_reset_seq.md
CLK_RESET_SEQ -- requirements
Module: clk_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized-locked cycles required before reset hold begins (range 1..65535).
REQ-002 SHALL have parameter RST_HOLD, default 256: cycles core_rst stays asserted after lock is qualified (range 1..65535).
REQ-003 SHALL have parameter CE_DIV, default 8: clock-enable divide ratio (power of two, range 2..64).
REQ-004 Port clk  input  1: core clock, PLL outclk_0 (48.648 MHz); the only clock.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port pll_locked  input  1: PLL locked; asynchronous to clk.
REQ-007 Port pause  input  1: freeze clock enables (present only with CLK_SEQ_PAUSE_EN).
REQ-008 Port core_rst  output  1: synchronous active-high reset to the game core.
REQ-009 Port ce_pix  output  1: one-cycle strobe every CE_DIV clk cycles (6.081 MHz at default).
REQ-010 Port ce_half  output  1: one-cycle strobe every 2*CE_DIV clk cycles, coincident with every second ce_pix.
REQ-011 Port ready  output  1: high only in state RUN.

Function
REQ-012 pll_locked SHALL pass through a 2-flop synchronizer; locked_s is its output; all logic uses locked_s only.
REQ-013 FSM states SHALL be WAIT_LOCK, STABLE, HOLD, RUN.
REQ-014 WAIT_LOCK: locked_s=1 -> STABLE with cnt cleared to 0; otherwise stay.
REQ-015 STABLE: cnt increments each cycle; locked_s=0 -> WAIT_LOCK; cnt=LOCK_STABLE-1 with locked_s=1 -> HOLD, cnt cleared.
REQ-016 HOLD: cnt increments each cycle; locked_s=0 -> WAIT_LOCK; cnt=RST_HOLD-1 -> RUN.
REQ-017 RUN: locked_s=0 -> WAIT_LOCK in the next cycle; otherwise stay.
REQ-018 core_rst SHALL be a registered output, 1 in every state except RUN, 0 from the first cycle in RUN.
REQ-019 Loss of lock in any state SHALL reassert core_rst on the cycle the FSM enters WAIT_LOCK; no glitch-free release is permitted before a full STABLE+HOLD sequence completes again.
REQ-020 Divider div_cnt (width log2(2*CE_DIV)) SHALL be held at 0 outside RUN and increment modulo 2*CE_DIV each RUN cycle.
REQ-021 ce_pix SHALL be registered, high when div_cnt mod CE_DIV = CE_DIV-1 in RUN; ce_half high when div_cnt = 2*CE_DIV-1 in RUN.
REQ-022 First ce_pix SHALL occur exactly CE_DIV cycles after the first RUN cycle; ce_pix, ce_half SHALL be 0 outside RUN.
REQ-023 Counters SHALL never wrap in STABLE/HOLD; cnt is 16 bits.

Reset
REQ-024 rst=1 SHALL asynchronously force: synchronizer flops 0, state WAIT_LOCK, cnt 0, div_cnt 0, core_rst 1, ce_pix 0, ce_half 0, ready 0.
REQ-025 rst deassertion SHALL take effect on the next clk edge; rst mid-RUN restarts the full sequence.

Configuration
REQ-026 With CLK_SEQ_PAUSE_EN defined: pause port exists; while pause=1 in RUN, div_cnt holds and ce_pix/ce_half are 0; release resumes from the held div_cnt; pause has no effect on FSM or core_rst.
REQ-027 Without CLK_SEQ_PAUSE_EN: no pause port; divider free-runs in RUN.

Structure
REQ-028 Package clk_seq_pkg SHALL hold the state enum type and default constants (LOCK_STABLE, RST_HOLD, CE_DIV defaults).
REQ-029 Sub-module sync_2ff (1-bit, async-reset-to-0 double flop) SHALL implement the locked synchronizer.

Verification (LOCK_STABLE=4, RST_HOLD=3, CE_DIV=8)
REQ-030 rst pulse, pll_locked=0 for 50 cycles -> core_rst=1, ready=0, no ce strobes.
REQ-031 pll_locked rises at cycle 0 -> locked_s at cycle 2, core_rst falls and ready rises 2+4+3+1 cycles later (cycle 10 +/-0, check exact edge), first ce_pix 8 cycles later, ce_half every 16.
REQ-032 pll_locked drops for 1 cycle during STABLE -> sequence restarts; core_rst stays 1 throughout.
REQ-033 pll_locked drops in RUN -> core_rst=1 and ready=0 within 3 cycles; strobes cease; relock repeats REQ-031 timing.
REQ-034 rst asserted mid-RUN, asynchronously between edges -> all outputs at reset values immediately, before next edge.
REQ-035 (CLK_SEQ_PAUSE_EN) pause=1 for 20 cycles in RUN -> zero strobes, div_cnt frozen; after release next ce_pix at the held phase.
